// File: rtl/sap_mem_pkg.sv
// Shared types and defaults for the RAM arbiter slice in front of ram8x256.
package sap_mem_pkg;

    localparam int unsigned RAM_AW = 8;
    localparam int unsigned RAM_DW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } ram_arb_state_t;

    typedef logic requester_id_t;

    localparam requester_id_t REQ_M0 = 1'b0;
    localparam requester_id_t REQ_M1 = 1'b1;

    typedef struct packed {
        logic              we;
        logic [RAM_AW-1:0] addr;
        logic [RAM_DW-1:0] wdata;
    } ram_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational pick: round-robin on ties when FAIR, else m0 always wins.
module rr_arb2
    import sap_mem_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic [1:0]    valid,
    input  requester_id_t last_grant,
    output logic [1:0]    grant
);

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
                if (FAIR && (last_grant == REQ_M0)) grant = 2'b10;
                else                                grant = 2'b01;
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_arb2.sv
// Sequences one RAM op at a time (IDLE -> ISSUE -> RESP) for two valid/ready masters.
module ram_arb2
    import sap_mem_pkg::*;
#(
    parameter int unsigned AW   = RAM_AW,
    parameter int unsigned DW   = RAM_DW,
    parameter bit          FAIR = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req_valid,
    output logic          m0_req_ready,
    input  logic          m0_req_we,
    input  logic [AW-1:0] m0_req_addr,
    input  logic [DW-1:0] m0_req_wdata,
    output logic          m0_rsp_valid,
    output logic [DW-1:0] m0_rsp_rdata,
    input  logic          m1_req_valid,
    output logic          m1_req_ready,
    input  logic          m1_req_we,
    input  logic [AW-1:0] m1_req_addr,
    input  logic [DW-1:0] m1_req_wdata,
    output logic          m1_rsp_valid,
    output logic [DW-1:0] m1_rsp_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_dout
);

    ram_arb_state_t state;
    requester_id_t  last_grant;
    requester_id_t  owner;
    requester_id_t  pick;
    logic [1:0]     valid;
    logic [1:0]     grant;
    logic           accept;
    logic           op_we;
    logic           in_resp;
    logic [DW-1:0]  rsp_data;
    logic [DW-1:0]  m0_rdata_q;
    logic [DW-1:0]  m1_rdata_q;

    assign valid = {m1_req_valid, m0_req_valid};

    rr_arb2 #(.FAIR(FAIR)) u_pick (
        .valid      (valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Ready is only offered from IDLE and is held low throughout reset.
    assign m0_req_ready = !rst && (state == IDLE) && grant[0];
    assign m1_req_ready = !rst && (state == IDLE) && grant[1];
    assign accept       = m0_req_ready | m1_req_ready;
    assign pick         = requester_id_t'(grant[1]);

    // RAM read data only lands during RESP, so the owner's rdata bypasses its hold register then.
    assign in_resp      = (state == RESP);
    assign rsp_data     = op_we ? '0 : ram_dout;
    assign m0_rsp_rdata = (in_resp && owner == REQ_M0) ? rsp_data : m0_rdata_q;
    assign m1_rsp_rdata = (in_resp && owner == REQ_M1) ? rsp_data : m1_rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_din      <= '0;
            op_we        <= 1'b0;
            owner        <= REQ_M0;
            last_grant   <= REQ_M1;
            m0_rsp_valid <= 1'b0;
            m1_rsp_valid <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ram_we <= 1'b0;
                    if (accept) begin
                        owner      <= pick;
                        last_grant <= pick;
                        op_we      <= pick ? m1_req_we    : m0_req_we;
                        ram_we     <= pick ? m1_req_we    : m0_req_we;
                        ram_addr   <= pick ? m1_req_addr  : m0_req_addr;
                        ram_din    <= pick ? m1_req_wdata : m0_req_wdata;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    ram_we       <= 1'b0;
                    m0_rsp_valid <= (owner == REQ_M0);
                    m1_rsp_valid <= (owner == REQ_M1);
                    state        <= RESP;
                end
                RESP: begin
                    m0_rsp_valid <= 1'b0;
                    m1_rsp_valid <= 1'b0;
                    if (owner == REQ_M0) m0_rdata_q <= rsp_data;
                    else                 m1_rdata_q <= rsp_data;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
